// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the 8-bit CPU control path: opcodes, control-word
// bit positions, fetch microwords and T-state names.
package cpu_ctrl_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam int C_HLT = 15;
  localparam int C_MI  = 14;
  localparam int C_RI  = 13;
  localparam int C_RO  = 12;
  localparam int C_IO  = 11;
  localparam int C_II  = 10;
  localparam int C_AI  = 9;
  localparam int C_AO  = 8;
  localparam int C_EO  = 7;
  localparam int C_SU  = 6;
  localparam int C_BI  = 5;
  localparam int C_OI  = 4;
  localparam int C_CE  = 3;
  localparam int C_CO  = 2;
  localparam int C_J   = 1;
  localparam int C_FI  = 0;

  localparam logic [15:0] CW_T0   = 16'h4004;
  localparam logic [15:0] CW_T1   = 16'h1408;
  localparam logic [15:0] CW_HALT = 16'h8000;

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } tstate_e;

  // One-hot control word with a single strobe set.
  function automatic logic [15:0] cb(input int idx);
    logic [15:0] w;
    w = '0;
    w[idx[3:0]] = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/microcode_rom.sv
// Combinational microcode: (opcode, T-state, flags) -> 16-bit control word.
// Steps beyond T4 decode to an empty word, which the lookahead relies on.
module microcode_rom
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0]  opcode,
  input  logic [2:0]  step,
  input  logic        flag_c,
  input  logic        flag_z,
  output logic [15:0] word
);

  always_comb begin
    word = '0;
    case (step)
      T0: word = CW_T0;
      T1: word = CW_T1;
      T2: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: word = cb(C_IO) | cb(C_MI);
          OP_LDI: word = cb(C_IO) | cb(C_AI);
          OP_JMP: word = cb(C_IO) | cb(C_J);
          OP_JC:  word = flag_c ? (cb(C_IO) | cb(C_J)) : '0;
          OP_JZ:  word = flag_z ? (cb(C_IO) | cb(C_J)) : '0;
          OP_OUT: word = cb(C_AO) | cb(C_OI);
          OP_HLT: word = cb(C_HLT);
          default: word = '0;
        endcase
      end
      T3: begin
        case (opcode)
          OP_LDA: word = cb(C_RO) | cb(C_AI);
          OP_ADD, OP_SUB: word = cb(C_RO) | cb(C_BI);
          OP_STA: word = cb(C_AO) | cb(C_RI);
          default: word = '0;
        endcase
      end
      T4: begin
        case (opcode)
          OP_ADD: word = cb(C_EO) | cb(C_AI) | cb(C_FI);
          OP_SUB: word = cb(C_EO) | cb(C_AI) | cb(C_SU) | cb(C_FI);
          default: word = '0;
        endcase
      end
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// T-state sequencer: step counter, halt latch and early-end lookahead,
// producing the control word that drives the CPU's bus strobes.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int NUM_STEPS = 5,
  parameter bit EARLY_END = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        step_en,
  input  logic [3:0]  opcode,
  input  logic        flag_c,
  input  logic        flag_z,
  output logic [15:0] ctrl,
  output logic [2:0]  step,
  output logic        halted
);

  localparam logic [2:0] LAST = 3'(NUM_STEPS - 1);

  logic [2:0]  step_q, step_d, step_la;
  logic        halt_q, halt_d;
  logic [15:0] word_cur, word_nxt;

  assign step_la = step_q + 3'd1;

  microcode_rom u_rom_cur (
    .opcode (opcode),
    .step   (step_q),
    .flag_c (flag_c),
    .flag_z (flag_z),
    .word   (word_cur)
  );

  microcode_rom u_rom_nxt (
    .opcode (opcode),
    .step   (step_la),
    .flag_c (flag_c),
    .flag_z (flag_z),
    .word   (word_nxt)
  );

  always_comb begin
    step_d = step_q;
    halt_d = halt_q;
    if (step_en && !halt_q) begin
      if (step_q == T2 && opcode == OP_HLT)
        halt_d = 1'b1;
      else if (step_q == LAST)
        step_d = T0;
      // Lookahead only from T2 on: before T1 ends the IR still holds the old opcode.
      else if (EARLY_END && step_q >= T2 && word_nxt == '0)
        step_d = T0;
      else
        step_d = step_la;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q <= T0;
      halt_q <= 1'b0;
    end else begin
      step_q <= step_d;
      halt_q <= halt_d;
    end
  end

  // Reset gating is combinational so the strobes drop with rst_n, not a clock later.
  assign ctrl   = !rst_n ? 16'h0000 : (halt_q ? CW_HALT : word_cur);
  assign step   = step_q;
  assign halted = halt_q;

endmodule
